// File: rtl/cpu_pkg.sv
// Shared encodings for the control sequencer: FSM states, opcodes, B-bus
// source selects and ALU operations.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_IDLE       = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_EXEC       = 5'd4,
        S_MEM_WAIT   = 5'd5,
        S_JMP_RD     = 5'd6,
        S_SKIP       = 5'd7,
        S_HALT       = 5'd8,
        S_FAULT      = 5'd9
    } state_e;

    typedef enum logic [4:0] {
        OP_NOP    = 5'h00,
        OP_CLAC   = 5'h01,
        OP_MVR    = 5'h02,
        OP_MVTR   = 5'h03,
        OP_MVAR   = 5'h04,
        OP_MVACR  = 5'h05,
        OP_MVACTR = 5'h06,
        OP_MVACAR = 5'h07,
        OP_INCAR  = 5'h08,
        OP_INCR   = 5'h09,
        OP_ADD    = 5'h0A,
        OP_SUB    = 5'h0B,
        OP_MUL4   = 5'h0C,
        OP_DIV2   = 5'h0D,
        OP_LDAC   = 5'h0E,
        OP_STAC   = 5'h0F,
        OP_JPNZ   = 5'h10,
        OP_JPZ    = 5'h11,
        OP_END    = 5'h12
    } opcode_e;

    typedef enum logic [3:0] {
        BUS_RAM = 4'd0,
        BUS_PC  = 4'd1,
        BUS_GPR = 4'd2,
        BUS_TR  = 4'd4,
        BUS_AC  = 4'd6,
        BUS_IR  = 4'd7,
        BUS_AR  = 4'd8
    } bus_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_PASS = 3'd2,
        ALU_ZERO = 3'd3,
        ALU_MUL4 = 3'd5,
        ALU_DIV2 = 3'd6
    } alu_op_e;

    // Opcodes are packed densely from zero, so anything past END is illegal.
    function automatic logic is_defined(input logic [4:0] opc);
        return opc <= 5'(OP_END);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory-request cycles and flags the cycle in
// which the stall count reaches WAIT_LIMIT.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] count;
    logic             stalled;

    assign stalled = active & ~ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (stalled)
            count <= count + 1'b1;
        else
            count <= '0;
    end

    assign timeout = stalled && (count == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Microcoded-style control FSM: fetch/decode/execute with memory handshakes,
// conditional jumps, and a wait-timeout fault path.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int INSTR_W    = 8,
    parameter int OPC_W      = 5,
    parameter int NUM_GPR    = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic               FLAG_Z,
    input  logic               MEM_READY,
    output logic               MEM_RD,
    output logic               MEM_WR,
    output logic [3:0]         BUS_SEL,
    output logic [2:0]         ALU_OP,
    output logic               LD_IR,
    output logic               LD_PC,
    output logic               LD_AR,
    output logic               LD_TR,
    output logic               LD_AC,
    output logic               INC_PC,
    output logic               INC_AR,
    output logic [NUM_GPR-1:0] LD_GPR,
    output logic [NUM_GPR-1:0] INC_GPR,
    output logic               FINISH,
    output logic               ERROR,
    output logic [4:0]         STATE
);

    localparam int IDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

    state_e             state, state_n;
    opcode_e            opc;
    logic [OPC_W-1:0]   opc_field;
    logic [IDX_W-1:0]   idx;
    logic [NUM_GPR-1:0] gpr_onehot;
    logic               timeout;
    logic               unused_instr;

    assign opc_field    = INSTRUCTION[INSTR_W-1 -: OPC_W];
    assign opc          = opcode_e'(5'(opc_field));
    assign idx          = INSTRUCTION[IDX_W-1:0];
    assign gpr_onehot   = NUM_GPR'(1) << idx;
    assign unused_instr = ^INSTRUCTION;
    assign STATE        = state;

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk     (CLOCK),
        .rst_n   (RESET_N),
        .active  (MEM_RD | MEM_WR),
        .ready   (MEM_READY),
        .timeout (timeout)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (START) state_n = S_FETCH;
            S_FETCH:      state_n = S_FETCH_WAIT;
            S_FETCH_WAIT: if (MEM_READY) state_n = S_DECODE;
            S_DECODE:     state_n = is_defined(opc) ? S_EXEC : S_FAULT;
            S_EXEC: begin
                case (opc)
                    OP_LDAC, OP_STAC: state_n = S_MEM_WAIT;
                    OP_JPNZ:          state_n = FLAG_Z ? S_SKIP : S_JMP_RD;
                    OP_JPZ:           state_n = FLAG_Z ? S_JMP_RD : S_SKIP;
                    OP_END:           state_n = S_HALT;
                    default:          state_n = S_FETCH;
                endcase
            end
            S_MEM_WAIT:   if (MEM_READY) state_n = S_FETCH;
            S_JMP_RD:     if (MEM_READY) state_n = S_FETCH;
            S_SKIP:       state_n = S_FETCH;
            S_HALT:       state_n = S_HALT;
            S_FAULT:      state_n = S_FAULT;
            default:      state_n = S_FAULT;
        endcase
        if (timeout)
            state_n = S_FAULT;
    end

    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        MEM_RD  = 1'b0;
        MEM_WR  = 1'b0;
        BUS_SEL = BUS_RAM;
        ALU_OP  = ALU_PASS;
        LD_IR   = 1'b0;
        LD_PC   = 1'b0;
        LD_AR   = 1'b0;
        LD_TR   = 1'b0;
        LD_AC   = 1'b0;
        INC_PC  = 1'b0;
        INC_AR  = 1'b0;
        LD_GPR  = '0;
        INC_GPR = '0;
        FINISH  = 1'b0;
        ERROR   = 1'b0;
        case (state)
            S_FETCH: begin
                BUS_SEL = BUS_PC;
                MEM_RD  = 1'b1;
            end
            S_FETCH_WAIT: begin
                MEM_RD = 1'b1;
                if (MEM_READY) begin
                    LD_IR  = 1'b1;
                    INC_PC = 1'b1;
                end else begin
                    BUS_SEL = BUS_PC;
                end
            end
            S_EXEC: begin
                case (opc)
                    OP_CLAC:   begin ALU_OP = ALU_ZERO; LD_AC = 1'b1; end
                    OP_MVR:    begin BUS_SEL = BUS_GPR; LD_AC = 1'b1; end
                    OP_MVTR:   begin BUS_SEL = BUS_TR;  LD_AC = 1'b1; end
                    OP_MVAR:   begin BUS_SEL = BUS_AR;  LD_AC = 1'b1; end
                    OP_MVACR:  begin BUS_SEL = BUS_AC;  LD_GPR = gpr_onehot; end
                    OP_MVACTR: begin BUS_SEL = BUS_AC;  LD_TR = 1'b1; end
                    OP_MVACAR: begin BUS_SEL = BUS_AC;  LD_AR = 1'b1; end
                    OP_INCAR:  INC_AR = 1'b1;
                    OP_INCR:   INC_GPR = gpr_onehot;
                    OP_ADD:    begin BUS_SEL = BUS_GPR; ALU_OP = ALU_ADD; LD_AC = 1'b1; end
                    OP_SUB:    begin BUS_SEL = BUS_GPR; ALU_OP = ALU_SUB; LD_AC = 1'b1; end
                    OP_MUL4:   begin ALU_OP = ALU_MUL4; LD_AC = 1'b1; end
                    OP_DIV2:   begin ALU_OP = ALU_DIV2; LD_AC = 1'b1; end
                    OP_LDAC:   begin BUS_SEL = BUS_AR;  MEM_RD = 1'b1; end
                    OP_STAC:   begin BUS_SEL = BUS_AC;  MEM_WR = 1'b1; end
                    default:   ;
                endcase
            end
            S_MEM_WAIT: begin
                // Only LDAC and STAC reach this state.
                if (opc == OP_STAC) begin
                    BUS_SEL = BUS_AC;
                    MEM_WR  = 1'b1;
                end else begin
                    MEM_RD = 1'b1;
                    if (MEM_READY)
                        LD_AC = 1'b1;
                    else
                        BUS_SEL = BUS_AR;
                end
            end
            S_JMP_RD: begin
                MEM_RD = 1'b1;
                if (MEM_READY)
                    LD_PC = 1'b1;
                else
                    BUS_SEL = BUS_PC;
            end
            S_SKIP:  INC_PC = 1'b1;
            S_HALT:  FINISH = 1'b1;
            S_FAULT: ERROR  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: fetch handshake,
// register moves, jumps, memory ops, timeout, undefined opcode, halt, reset.
module tb_control_sequencer;
    import cpu_pkg::*;

    logic       CLOCK, RESET_N, START, FLAG_Z, MEM_READY;
    logic [7:0] INSTRUCTION;
    logic       MEM_RD, MEM_WR, LD_IR, LD_PC, LD_AR, LD_TR, LD_AC, INC_PC, INC_AR;
    logic       FINISH, ERROR;
    logic [3:0] BUS_SEL, LD_GPR, INC_GPR;
    logic [2:0] ALU_OP;
    logic [4:0] STATE;

    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .INSTRUCTION(INSTRUCTION),
        .FLAG_Z(FLAG_Z), .MEM_READY(MEM_READY), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .BUS_SEL(BUS_SEL), .ALU_OP(ALU_OP), .LD_IR(LD_IR), .LD_PC(LD_PC),
        .LD_AR(LD_AR), .LD_TR(LD_TR), .LD_AC(LD_AC), .INC_PC(INC_PC),
        .INC_AR(INC_AR), .LD_GPR(LD_GPR), .INC_GPR(INC_GPR), .FINISH(FINISH),
        .ERROR(ERROR), .STATE(STATE)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All load/increment/memory strobes, excluding the FINISH/ERROR status bits.
    function automatic logic [16:0] strobes();
        return {MEM_RD, MEM_WR, LD_IR, LD_PC, LD_AR, LD_TR, LD_AC, INC_PC, INC_AR,
                LD_GPR, INC_GPR};
    endfunction

    function automatic logic [7:0] mk(input opcode_e op, input int idx);
        return {op, 3'(idx)};
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Entered while in FETCH; leaves the sequencer in DECODE.
    task automatic fetch(input logic [7:0] instr, input int late);
        INSTRUCTION = instr;
        check("fetch_state", 32'(STATE), 1);
        check("fetch_bus_pc", 32'(BUS_SEL), 1);
        check("fetch_mem_rd", 32'(MEM_RD), 1);
        tick();
        repeat (late) tick();
        check("fwait_state", 32'(STATE), 2);
        check("fwait_no_ld_ir", 32'(LD_IR), 0);
        MEM_READY = 1'b1;
        #1;
        check("fwait_ld_ir", 32'(LD_IR), 1);
        check("fwait_inc_pc", 32'(INC_PC), 1);
        tick();
        MEM_READY = 1'b0;
        #1;
        check("decode_state", 32'(STATE), 3);
        check("decode_quiet", 32'(strobes()), 0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        check("reset_state", 32'(STATE), 0);
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; FLAG_Z = 1'b0; MEM_READY = 1'b0; INSTRUCTION = '0;
        #2;
        check("rst_state", 32'(STATE), 0);
        check("rst_alu_pass", 32'(ALU_OP), 2);
        check("rst_bus", 32'(BUS_SEL), 0);
        check("rst_strobes", 32'(strobes()), 0);
        check("rst_status", 32'({FINISH, ERROR}), 0);
        #1 RESET_N = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;

        // CLAC with memory ready two cycles late
        fetch(mk(OP_CLAC, 0), 2);
        tick();
        check("clac_state", 32'(STATE), 4);
        check("clac_ld_ac", 32'(LD_AC), 1);
        check("clac_alu_zero", 32'(ALU_OP), 3);
        tick();
        check("clac_back_fetch", 32'(STATE), 1);

        // MVACR idx=2
        fetch(mk(OP_MVACR, 2), 0);
        tick();
        check("mvacr_ld_gpr", 32'(LD_GPR), 4);
        check("mvacr_bus_ac", 32'(BUS_SEL), 6);
        check("mvacr_inc_gpr", 32'(INC_GPR), 0);
        tick();
        check("mvacr_one_cycle", 32'(LD_GPR), 0);

        // INCR idx=3
        fetch(mk(OP_INCR, 3), 0);
        tick();
        check("incr_inc_gpr", 32'(INC_GPR), 8);
        check("incr_ld_gpr", 32'(LD_GPR), 0);
        tick();

        // ADD idx=1
        fetch(mk(OP_ADD, 1), 0);
        tick();
        check("add_bus_gpr", 32'(BUS_SEL), 2);
        check("add_alu", 32'(ALU_OP), 0);
        check("add_ld_ac", 32'(LD_AC), 1);
        tick();

        // JPNZ not taken (Z=1) -> SKIP
        fetch(mk(OP_JPNZ, 0), 0);
        FLAG_Z = 1'b1;
        tick();
        check("jpnz_exec_no_rd", 32'(MEM_RD), 0);
        tick();
        FLAG_Z = 1'b0;
        check("jpnz_skip_state", 32'(STATE), 7);
        check("jpnz_skip_inc_pc", 32'(INC_PC), 1);
        check("jpnz_skip_no_rd", 32'(MEM_RD), 0);
        tick();
        check("skip_to_fetch", 32'(STATE), 1);

        // JPNZ taken (Z=0) -> operand read then LD_PC
        fetch(mk(OP_JPNZ, 0), 0);
        tick();
        tick();
        check("jmp_state", 32'(STATE), 6);
        check("jmp_mem_rd", 32'(MEM_RD), 1);
        check("jmp_bus_pc", 32'(BUS_SEL), 1);
        check("jmp_no_ld_pc", 32'(LD_PC), 0);
        tick();
        MEM_READY = 1'b1;
        #1;
        check("jmp_ld_pc", 32'(LD_PC), 1);
        check("jmp_bus_ram", 32'(BUS_SEL), 0);
        tick();
        MEM_READY = 1'b0;
        check("jmp_to_fetch", 32'(STATE), 1);

        // JPZ with Z=0 -> not taken
        fetch(mk(OP_JPZ, 0), 0);
        tick();
        tick();
        check("jpz_skip_state", 32'(STATE), 7);
        tick();

        // LDAC normal
        fetch(mk(OP_LDAC, 0), 0);
        tick();
        check("ldac_mem_rd", 32'(MEM_RD), 1);
        check("ldac_bus_ar", 32'(BUS_SEL), 8);
        tick();
        MEM_READY = 1'b1;
        #1;
        check("ldac_ld_ac", 32'(LD_AC), 1);
        check("ldac_alu_pass", 32'(ALU_OP), 2);
        check("ldac_bus_ram", 32'(BUS_SEL), 0);
        tick();
        MEM_READY = 1'b0;
        check("ldac_to_fetch", 32'(STATE), 1);

        // STAC
        fetch(mk(OP_STAC, 0), 0);
        tick();
        check("stac_wr_rd", 32'({MEM_WR, MEM_RD}), 2);
        check("stac_bus_ac", 32'(BUS_SEL), 6);
        tick();
        MEM_READY = 1'b1;
        #1;
        check("stac_wait_wr", 32'({MEM_WR, MEM_RD}), 2);
        tick();
        MEM_READY = 1'b0;
        check("stac_to_fetch", 32'(STATE), 1);

        // LDAC timeout: EXEC plus 14 MEM_WAIT cycles stalled, then FAULT
        fetch(mk(OP_LDAC, 0), 0);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("to_still_wait", 32'(STATE), 5);
        check("to_no_error_yet", 32'(ERROR), 0);
        tick();
        check("to_fault_state", 32'(STATE), 9);
        check("to_error", 32'(ERROR), 1);
        check("to_strobes_zero", 32'(strobes()), 0);
        MEM_READY = 1'b1;
        tick();
        check("fault_ignores_ready", 32'(STATE), 9);
        MEM_READY = 1'b0;
        do_reset();
        START = 1'b1;
        tick();
        START = 1'b0;

        // undefined opcode 5'h1F
        fetch(8'hF8, 0);
        tick();
        check("undef_fault", 32'(STATE), 9);
        check("undef_error", 32'(ERROR), 1);
        do_reset();
        START = 1'b1;
        tick();
        START = 1'b0;

        // END -> HALT, START and MEM_READY ignored
        fetch(mk(OP_END, 0), 0);
        tick();
        tick();
        check("halt_state", 32'(STATE), 8);
        check("halt_finish", 32'(FINISH), 1);
        START = 1'b1;
        MEM_READY = 1'b1;
        repeat (3) tick();
        check("halt_held_state", 32'(STATE), 8);
        check("halt_held_finish", 32'(FINISH), 1);
        check("halt_strobes_zero", 32'(strobes()), 0);
        START = 1'b0;
        MEM_READY = 1'b0;
        do_reset();
        check("reset_clears_finish", 32'(FINISH), 0);

        // async reset mid FETCH_WAIT
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("fw_before_reset", 32'(MEM_RD), 1);
        #2 RESET_N = 1'b0;
        #1;
        check("async_mem_rd", 32'(MEM_RD), 0);
        check("async_state", 32'(STATE), 0);
        check("async_bus", 32'(BUS_SEL), 0);
        check("async_alu", 32'(ALU_OP), 2);
        RESET_N = 1'b1;
        tick();
        check("idle_after_reset", 32'(STATE), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
